// File: rtl/muldiv_pkg.sv
// Shared types and constants for the E-stage multiply/divide unit.
// Defining MULDIV_MADD_EN widens op to 4 bits and adds the multiply-accumulate ops.
package muldiv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned DIV_STEPS = 32;
    localparam int unsigned CNT_W     = 5;

`ifdef MULDIV_MADD_EN
    localparam int unsigned OP_W = 4;
`else
    localparam int unsigned OP_W = 3;
`endif

    // MADDU/MSUBU reuse the MADD/MSUB low bits with the variant bit set
    typedef enum logic [OP_W-1:0] {
        OP_MULT  = OP_W'(0),
        OP_MULTU = OP_W'(1),
        OP_DIV   = OP_W'(2),
        OP_DIVU  = OP_W'(3),
        OP_MTHI  = OP_W'(4),
        OP_MTLO  = OP_W'(5),
        OP_MADD  = OP_W'(6),
        OP_MSUB  = OP_W'(7)
`ifdef MULDIV_MADD_EN
        ,
        OP_MADDU = OP_W'(14),
        OP_MSUBU = OP_W'(15)
`endif
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_e;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_ADD,
        ACC_SUB
    } acc_e;

endpackage

// File: rtl/muldiv_e_div_step.sv
// One restoring-division step: shift the next dividend bit in, trial subtract, set quotient bit.
module div_step_unit
    import muldiv_pkg::*;
(
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvsr_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - {2'b00, dvsr_i};
        if (diff[XLEN+1]) begin
            rem_o = shifted[XLEN:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end else begin
            rem_o = diff[XLEN:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_e.sv
// E-stage multiply/divide unit owning HI/LO: multi-cycle multiply and restoring divide.
// Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulate ops.
module muldiv_e
    import muldiv_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            flush,
    input  logic            hilo_use,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO,
    output logic            busy,
    output logic            stall_req
);

    state_e              state_q, state_d;
    acc_e                acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [XLEN:0]       rem_q, rem_d;
    logic [XLEN-1:0]     quo_q, quo_d, dvsr_q, dvsr_d, a_q, a_d;
    logic                negq_q, negq_d, negr_q, negr_d, div0_q, div0_d;
    logic                busy_q;

    logic [2*XLEN-1:0]   prod_s, prod_u, acc_res;
    logic [XLEN-1:0]     a_abs, b_abs, quo_fix, rem_fix, step_quo;
    logic [XLEN:0]       step_rem;
    logic                is_div_s;

    // Low 64 bits of the sign-extended product equal the signed product
    assign prod_s   = {{XLEN{A[XLEN-1]}}, A} * {{XLEN{B[XLEN-1]}}, B};
    assign prod_u   = {{XLEN{1'b0}}, A} * {{XLEN{1'b0}}, B};
    assign is_div_s = (op == OP_DIV);
    assign a_abs    = (is_div_s && A[XLEN-1]) ? (~A + XLEN'(1)) : A;
    assign b_abs    = (is_div_s && B[XLEN-1]) ? (~B + XLEN'(1)) : B;
    assign quo_fix  = negq_q ? (~quo_q + XLEN'(1)) : quo_q;
    assign rem_fix  = negr_q ? (~rem_q[XLEN-1:0] + XLEN'(1)) : rem_q[XLEN-1:0];

    div_step_unit u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .quo_o  (step_quo)
    );

    // Accumulator is read at commit time, not at issue
    always_comb begin
        case (acc_q)
            ACC_ADD: acc_res = {hi_q, lo_q} + prod_q;
            ACC_SUB: acc_res = {hi_q, lo_q} - prod_q;
            default: acc_res = prod_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        a_d     = a_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        div0_d  = div0_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            prod_d  = (op == OP_MULT) ? prod_s : prod_u;
                            acc_d   = ACC_NONE;
                            cnt_d   = CNT_W'(MULT_CYCLES - 1);
                            state_d = S_MUL;
                        end
`ifdef MULDIV_MADD_EN
                        OP_MADD, OP_MSUB, OP_MADDU, OP_MSUBU: begin
                            prod_d  = (op == OP_MADD || op == OP_MSUB) ? prod_s : prod_u;
                            acc_d   = (op == OP_MADD || op == OP_MADDU) ? ACC_ADD : ACC_SUB;
                            cnt_d   = CNT_W'(MULT_CYCLES - 1);
                            state_d = S_MUL;
                        end
`endif
                        OP_DIV, OP_DIVU: begin
                            rem_d   = '0;
                            quo_d   = a_abs;
                            dvsr_d  = b_abs;
                            a_d     = A;
                            negq_d  = is_div_s && (A[XLEN-1] ^ B[XLEN-1]);
                            negr_d  = is_div_s && A[XLEN-1];
                            div0_d  = (B == '0);
                            cnt_d   = CNT_W'(DIV_STEPS - 1);
                            state_d = S_DIV;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = acc_res;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (div0_q) begin
                        lo_d = '1;
                        hi_d = a_q;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= ACC_NONE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            a_q     <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            div0_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            a_q     <= a_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            div0_q  <= div0_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign HI        = hi_q;
    assign LO        = lo_q;
    assign busy      = busy_q;
    assign stall_req = hilo_use & busy_q;

endmodule

// File: tb/tb_muldiv_e.sv
// Scoreboard bench for muldiv_e: driver pushes model results, monitor pops on busy completion.
module tb_muldiv_e;
    import muldiv_pkg::*;

    localparam int unsigned MC = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [OP_W-1:0] op;
    logic [31:0]     A, B;
    logic            flush;
    logic            hilo_use;
    logic [31:0]     HI, LO;
    logic            busy;
    logic            stall_req;

    logic [63:0]     sb_q[$];
    logic            exp_busy = 1'b0;
    logic [31:0]     mh = '0, ml = '0;
    int              checks = 0;
    int              errors = 0;

    muldiv_e #(.MULT_CYCLES(MC)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .A         (A),
        .B         (B),
        .flush     (flush),
        .hilo_use  (hilo_use),
        .HI        (HI),
        .LO        (LO),
        .busy      (busy),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural reference: plain arithmetic on the operation's definition
    function automatic void model(input logic [OP_W-1:0] opc, input logic [31:0] a, b,
                                  input logic [31:0] hi0, lo0,
                                  output logic [31:0] hi1, lo1, output int n);
        longint sp;
        hi1 = hi0;
        lo1 = lo0;
        n   = 0;
        sp  = longint'(int'(a)) * longint'(int'(b));
        case (int'(opc))
            0: begin {hi1, lo1} = sp; n = MC; end
            1: begin {hi1, lo1} = {32'd0, a} * {32'd0, b}; n = MC; end
            2, 3: begin
                n = 33;
                if (b == 0) begin
                    lo1 = 32'hFFFFFFFF;
                    hi1 = a;
                end else if (opc == 3) begin
                    lo1 = a / b;
                    hi1 = a % b;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    lo1 = 32'h80000000;
                    hi1 = 32'h0;
                end else begin
                    lo1 = 32'(int'(a) / int'(b));
                    hi1 = 32'(int'(a) % int'(b));
                end
            end
            4: hi1 = a;
            5: lo1 = a;
`ifdef MULDIV_MADD_EN
            6: begin {hi1, lo1} = {hi0, lo0} + 64'(sp); n = MC; end
            7: begin {hi1, lo1} = {hi0, lo0} - 64'(sp); n = MC; end
`endif
            default: ;
        endcase
    endfunction

    // flush_k: >0 flush during that busy cycle, <0 flush together with start
    task automatic issue(input logic [OP_W-1:0] opc, input logic [31:0] a, b,
                         input int flush_k, input int dup_k);
        logic [31:0] nh, nl;
        int n, len;
        model(opc, a, b, mh, ml, nh, nl, n);
        if (flush_k < 0) begin
            nh = mh;
            nl = ml;
            n  = 0;
        end
        len = (flush_k > 0 && flush_k <= n) ? flush_k : n;
        if (n > 0) sb_q.push_back((len < n) ? {mh, ml} : {nh, nl});
        start    = 1'b1;
        op       = opc;
        A        = a;
        B        = b;
        flush    = (flush_k < 0);
        hilo_use = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start    = 1'b0;
        flush    = 1'b0;
        A        = $urandom;
        B        = $urandom;
        exp_busy = (n > 0);
        for (int k = 1; k <= len; k++) begin
            hilo_use = 1'($urandom_range(0, 1));
            flush    = (k == flush_k);
            if (k == dup_k) begin
                start = 1'b1;
                op    = OP_W'($urandom_range(0, 5));
            end
            @(posedge clk); #1;
            flush = 1'b0;
            start = 1'b0;
        end
        exp_busy = 1'b0;
        if (len == n) begin
            mh = nh;
            ml = nl;
        end
        if (n == 0) chk("hilo_immediate", {HI, LO}, {mh, ml});
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: per-cycle busy/stall, and scoreboard pop whenever busy falls
    initial begin : monitor
        logic prev;
        logic [63:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("stall_req", 64'(stall_req), 64'(hilo_use & exp_busy));
            if (prev && !busy) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: completion with no expected entry at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("commit_hilo", {HI, LO}, e);
                end
            end
            prev = busy;
        end
    end

    initial begin : driver
        rst      = 1'b1;
        start    = 1'b0;
        op       = '0;
        A        = '0;
        B        = '0;
        flush    = 1'b0;
        hilo_use = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_hilo", {HI, LO}, 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);

        issue(OP_MULT, 32'd7, 32'hFFFFFFFD, 0, 0);
        chk("tp_mult", {HI, LO}, 64'hFFFFFFFF_FFFFFFEB);
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        chk("tp_multu", {HI, LO}, 64'hFFFFFFFE_00000001);
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 0, 0);
        chk("tp_div_neg", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        chk("tp_div_ovf", {HI, LO}, 64'h00000000_80000000);
        issue(OP_DIVU, 32'd100, 32'd0, 0, 7);
        chk("tp_divu_zero", {HI, LO}, 64'h00000064_FFFFFFFF);
        issue(OP_MTHI, 32'h12345678, 32'd0, 0, 0);
        issue(OP_DIV, 32'd1000, 32'd3, 10, 0);
        chk("tp_flush_hi", 64'(HI), 64'h12345678);
        issue(OP_MTLO, 32'hDEADBEEF, 32'd0, -1, 0);
        chk("flush_with_start", {HI, LO}, {32'h12345678, ml});

        for (int i = 0; i < 40; i++) begin
            int fk, dk;
            fk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 33)) : 0;
            dk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 33)) : 0;
            issue(OP_W'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), fk, dk);
        end

        // Asynchronous reset between edges while a multiply is in flight
        issue(OP_MTHI, 32'hA5A5A5A5, 32'd0, 0, 0);
        sb_q.push_back(64'h0);
        start = 1'b1;
        op    = OP_MULT;
        A     = 32'd9;
        B     = 32'd9;
        @(posedge clk); #1;
        start    = 1'b0;
        exp_busy = 1'b1;
        @(posedge clk); #3;
        rst      = 1'b1;
        exp_busy = 1'b0;
        #1;
        chk("async_rst_hilo", {HI, LO}, 64'h0);
        chk("async_rst_busy", 64'(busy), 64'h0);
        mh = '0;
        ml = '0;
        @(posedge clk); #1 rst = 1'b0;
        issue(OP_MULT, 32'd3, 32'd4, 0, 0);
        chk("tp_mult_after_rst", {HI, LO}, 64'h00000000_0000000C);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
